// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared types and sizing for the sequential binary-to-BCD (double-dabble) converter.
package bin_to_bcd_converter_pkg;

    localparam int unsigned BIN_WIDTH      = 32;
    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned BCD_DIGITS_INT = 10;
    localparam int unsigned BCD_DIGITS_OUT = 8;
    localparam int unsigned ACC_W          = BCD_DIGITS_INT * DIGIT_W;
    localparam int unsigned OUT_W          = BCD_DIGITS_OUT * DIGIT_W;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned ITER_LAST      = 31;

    localparam logic [BCD_DIGITS_OUT-1:0] LZ_MASK_RST = BCD_DIGITS_OUT'(8'hFE);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bin_to_bcd_converter_add3.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more.
module bcd_add3_digit
    import bin_to_bcd_converter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] adj_c_o
);

    always_comb begin
        adj_c_o = digit_i;
        if (digit_i >= DIGIT_W'(5)) begin
            adj_c_o = digit_i + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// 32-bit binary to 8-digit packed BCD converter, one shift per cycle, atomic result update.
module bin_to_bcd_converter
    import bin_to_bcd_converter_pkg::*;
#(
    parameter bit AUTO = 1'b0
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start_in,
    input  logic [BIN_WIDTH-1:0]      val_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [OUT_W-1:0]          bcd_out,
    output logic                      ovf_out,
    output logic [BCD_DIGITS_OUT-1:0] lz_mask_out
);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]        shift_q, shift_d;
    logic [ACC_W-1:0]            acc_q, acc_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [OUT_W-1:0]            bcd_q, bcd_d;
    logic                        ovf_q, ovf_d;
    logic [BCD_DIGITS_OUT-1:0]   lz_q, lz_d;

    logic [ACC_W-1:0]            acc_adj_c;
    logic [ACC_W-1:0]            acc_next_c;
    logic [BIN_WIDTH-1:0]        shift_next_c;
    logic                        ovf_c;
    logic [BCD_DIGITS_OUT-1:0]   lz_c;
    logic                        unused_acc_msb_c;

    for (genvar g = 0; g < BCD_DIGITS_INT; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_i (acc_q[g*DIGIT_W +: DIGIT_W]),
            .adj_c_o (acc_adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Top digit never exceeds 4, so the bit shifted out of the accumulator is always 0.
    assign unused_acc_msb_c = acc_adj_c[ACC_W-1];
    assign acc_next_c       = {acc_adj_c[ACC_W-2:0], shift_q[BIN_WIDTH-1]};
    assign shift_next_c     = {shift_q[BIN_WIDTH-2:0], 1'b0};
    assign ovf_c            = |acc_next_c[ACC_W-1:OUT_W];

    // Leading-zero mask over the final digits; suppressed entirely on overflow.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_c     = '0;
        for (int i = BCD_DIGITS_OUT - 1; i >= 1; i--) begin
            all_zero = all_zero & (acc_next_c[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(0));
            lz_c[i]  = all_zero & ~ovf_c;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        lz_d    = lz_q;
        case (state_q)
            IDLE: begin
                if (start_in || AUTO) begin
                    shift_d = val_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shift_next_c;
                acc_d   = acc_next_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_LAST)) begin
                    bcd_d   = acc_next_c[OUT_W-1:0];
                    ovf_d   = ovf_c;
                    lz_d    = lz_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            lz_q    <= LZ_MASK_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            lz_q    <= lz_d;
        end
    end

    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign bcd_out     = bcd_q;
    assign ovf_out     = ovf_q;
    assign lz_mask_out = lz_q;

endmodule

// File: doc/bin_to_bcd_converter.md
# bin_to_bcd_converter

Sequential double-dabble converter that turns a 32-bit binary value (typically a CPU register or debug bus value) into eight packed BCD digits. It sits directly upstream of the seven-segment display controller: its `bcd_out` drives that controller's 32-bit nibble-per-digit value input, so displayed numbers read in decimal instead of hex. Results update atomically, so the display never shows a half-converted value.

## Interface
- `AUTO`, default 0: 1 = free-running; restarts a conversion every time one completes and ignores `start_in`. 0 = converts only on `start_in`.
- `clk_in`  input  1  system clock; all state changes on its rising edge.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `start_in`  input  1  conversion request; sampled only while idle.
- `val_in`  input  32  unsigned binary value; sampled on the accepting edge only.
- `busy_out`  output  1  high while a conversion is in progress.
- `done_out`  output  1  one-cycle pulse when `bcd_out` is updated.
- `bcd_out`  output  32  eight BCD digits; digit i is in bits [4i+3:4i]; units digit in [3:0].
- `ovf_out`  output  1  value exceeds 99 999 999; `bcd_out` then holds the low 8 decimal digits.
- `lz_mask_out`  output  8  bit i = 1 when digit i and every higher digit are zero (i ≥ 1); bit 0 is always 0.

## Operation
- States: IDLE and SHIFT.
- **IDLE.** If `start_in`=1, or `AUTO`=1:
  - Latch `val_in` into a 32-bit shift register.
  - Clear the 40-bit (10-digit) BCD accumulator.
  - Set iteration counter to 0 and go to SHIFT.
- **SHIFT.** Each cycle, in one step:
  - Add 3 to every accumulator digit ≥ 5.
  - Shift {accumulator, shift register} left by 1 and increment the counter.
- **Last iteration.** On the iteration with counter = 31, the final accumulator value is computed combinationally and registered the same edge:
  - `bcd_out` ← accumulator[31:0].
  - `ovf_out` ← (accumulator[39:32] ≠ 0).
  - `lz_mask_out` is computed from the final digits; it is all zeros if `ovf_out`=1.
  - `done_out` ← 1 and the FSM returns to IDLE.
- `start_in` while busy is ignored; no queuing.
- Back-to-back operation: `start_in` high during the `done_out` cycle is accepted, since the FSM is already in IDLE.
- `bcd_out`, `ovf_out` and `lz_mask_out` change only on completion edges and hold their values otherwise.
- Arithmetic: add-3 is 4-bit and never overflows (max input 9 → 12). The accumulator is 10 digits so any 32-bit input converts exactly. Max input 4 294 967 295 → accumulator 0x42_9496_7295.

## Timing
- **Reset values:** `busy_out`=0, `done_out`=0, `bcd_out`=0x0000_0000, `ovf_out`=0, `lz_mask_out`=0xFE, FSM = IDLE, counter = 0.
- **Start edge E0:** request is accepted; `busy_out`=1 in the cycle after E0.
- **Edges E1..E32:** perform the 32 shifts.
- **Edge E32:** outputs update, `done_out`=1 and `busy_out`=0 for the cycle after E32.
- **Latency:** 32 cycles from the accepting edge to valid outputs.
- **`AUTO`=1:** steady state is one result every 33 cycles. Edge E32 returns to IDLE and the next edge re-accepts; `busy_out` drops for exactly one cycle between conversions.
- **Reset mid-conversion:** aborts immediately; all outputs return to their reset values, including `bcd_out`.
- `done_out` is never high for more than one consecutive cycle.

## Structure
- Shared package holds:
  - state enum {IDLE, SHIFT};
  - `BIN_WIDTH`=32, `BCD_DIGITS_INT`=10, `BCD_DIGITS_OUT`=8;
  - `ITER_LAST`=31;
  - counter width (5 bits).
- One sub-module, `bcd_add3_digit`: combinational 4-bit "add 3 if ≥ 5" correction, instantiated 10 times via generate.
- Leading-zero mask and overflow logic live in the top module.

## Test plan
- Reset released, `start_in`=0 for 50 cycles → `bcd_out`=0x00000000, `lz_mask_out`=0xFE, `busy_out`=0, no `done_out`.
- `val_in`=12 345 678, 1-cycle start → `busy_out` next cycle; `done_out` exactly 32 cycles after start edge; `bcd_out`=0x12345678, `ovf_out`=0, `lz_mask_out`=0x00.
- `val_in`=42 then 0 (second start during the `done_out` cycle) → results 0x00000042 / mask 0xFC, then 0x00000000 / mask 0xFE; `val_in` changed mid-conversion does not affect the result.
- `val_in`=0xFFFF_FFFF → `bcd_out`=0x94967295, `ovf_out`=1, `lz_mask_out`=0x00; `val_in`=100 000 000 → `bcd_out`=0x00000000, `ovf_out`=1.
- `start_in` pulsed at cycles 5 and 20 after accept → ignored; single `done_out`; `rst_n_in` low at cycle 16 of a later conversion → outputs at reset values immediately, no `done_out`.
- `AUTO`=1, `val_in`=999 → `done_out` every 33 cycles, `bcd_out`=0x00000999 stable, `lz_mask_out`=0xF8.
